// File: rtl/ariane_pkg.sv
// Minimal slice of ariane_pkg: scoreboard transaction-id width shared by all functional units.
package ariane_pkg;
    localparam int unsigned NR_SB_ENTRIES = 8;
    localparam int unsigned TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);
endpackage

// File: rtl/pau_pkg.sv
// Shared types and default sizing for the posit arithmetic unit writeback path.
package pau_pkg;
    typedef struct packed {
        logic [ariane_pkg::TRANS_ID_BITS-1:0] trans_id;
        riscv::xlen_t                         result;
    } pau_wb_entry_t;

    localparam int unsigned PAU_WB_DEPTH   = 4;
    localparam int unsigned PAU_WB_RESERVE = 2;
endpackage

// File: rtl/riscv_pkg.sv
// Minimal slice of the core's riscv package: machine word width used by the PAU datapath.
package riscv;
    localparam int unsigned XLEN = 64;
    typedef logic [XLEN-1:0] xlen_t;
endpackage

// File: rtl/pau_wb_queue_if.sv
// PAU completion and writeback handshake bundle; the queue is the slave, the pipeline the master.
interface pau_wb_queue_if;
    logic                                 pau_valid_i;
    logic [ariane_pkg::TRANS_ID_BITS-1:0] pau_trans_id_i;
    riscv::xlen_t                         pau_result_i;
    logic                                 wb_valid_o;
    logic [ariane_pkg::TRANS_ID_BITS-1:0] wb_trans_id_o;
    riscv::xlen_t                         wb_result_o;
    logic                                 wb_ready_i;

    modport master (
        output pau_valid_i, pau_trans_id_i, pau_result_i, wb_ready_i,
        input  wb_valid_o, wb_trans_id_o, wb_result_o
    );

    modport slave (
        input  pau_valid_i, pau_trans_id_i, pau_result_i, wb_ready_i,
        output wb_valid_o, wb_trans_id_o, wb_result_o
    );
endinterface

// File: rtl/pau_wb_queue_mem.sv
// Result storage for pau_wb_queue: DEPTH entries, one write port, asynchronous read, no data reset.
module pau_wb_mem
    import pau_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  pau_wb_entry_t wdata_i,
    input  logic [AW-1:0] raddr_i,
    output pau_wb_entry_t rdata_o
);
    pau_wb_entry_t mem_q [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk_i) begin
            if (we_i && (waddr_i == AW'(gi))) begin
                mem_q[gi] <= wdata_i;
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/pau_wb_queue.sv
// Writeback result queue behind the PAU; throttles PAU issue so no completion is lost.
// Define PAU_WB_BYPASS_EN to forward a completion straight to writeback when the queue is empty.
module pau_wb_queue
    import pau_pkg::*;
#(
    parameter int unsigned DEPTH   = PAU_WB_DEPTH,
    parameter int unsigned RESERVE = PAU_WB_RESERVE
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           flush_i,
    pau_wb_queue_if.slave  bus,
    output logic           issue_block_o,
    output logic           overflow_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] BLOCK_CNT = CW'(DEPTH - RESERVE);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          stored_valid, bypass, push, pop, drop;
    pau_wb_entry_t wdata, head;

    assign stored_valid = (count_q != '0);

`ifdef PAU_WB_BYPASS_EN
    assign bypass = ~stored_valid & bus.pau_valid_i & ~flush_i;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed result that writeback takes immediately never occupies an entry.
    assign pop  = stored_valid & bus.wb_ready_i & ~flush_i;
    assign push = bus.pau_valid_i & ~flush_i & ((count_q != FULL_CNT) | pop)
                & ~(bypass & bus.wb_ready_i);
    assign drop = bus.pau_valid_i & ~flush_i & (count_q == FULL_CNT) & ~pop;

    assign wdata.trans_id = bus.pau_trans_id_i;
    assign wdata.result   = bus.pau_result_i;

    pau_wb_mem #(.DEPTH(DEPTH)) i_mem (
        .clk_i   (clk_i),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (wdata),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = drop;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        bus.wb_valid_o    = stored_valid | bypass;
        bus.wb_trans_id_o = '0;
        bus.wb_result_o   = '0;
        if (stored_valid) begin
            bus.wb_trans_id_o = head.trans_id;
            bus.wb_result_o   = head.result;
        end else if (bypass) begin
            bus.wb_trans_id_o = bus.pau_trans_id_i;
            bus.wb_result_o   = bus.pau_result_i;
        end
    end

    assign issue_block_o = (count_q >= BLOCK_CNT);
    assign overflow_o    = overflow_q;
endmodule
